pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 8, data path width in bits; legal range 1..64.
REQ-002 Parameter RESET_VALUE, default 0, WIDTH-bit value driven on out_data after reset.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous discard of all held entries.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 in_ready  output  1  stage can accept an entry this cycle.
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_data  output  WIDTH  oldest held entry.
REQ-011 out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 occupancy  output  2  number of held entries, 0..2.

Function
REQ-013 The block SHALL be a two-entry skid-buffered pipeline register: a main register (drives out_data) and a skid register.
REQ-014 push SHALL be in_valid && in_ready; pop SHALL be out_valid && out_ready.
REQ-015 State machine states: EMPTY (occupancy 0), FULL (1, main valid), SKID (2, main and skid valid).
REQ-016 out_valid SHALL be 1 in FULL and SKID, 0 in EMPTY; in_ready SHALL be 1 in EMPTY and FULL, 0 in SKID; both decoded from registered state only, with no combinational path from in_valid or out_ready.
REQ-017 EMPTY: push -> FULL, main <= in_data; otherwise stay.
REQ-018 FULL: push and pop -> FULL, main <= in_data; push only -> SKID, skid <= in_data; pop only -> EMPTY; neither -> stay.
REQ-019 SKID: pop -> FULL, main <= skid; no pop -> stay, main and skid unchanged.
REQ-020 Latency SHALL be one cycle: data pushed on edge N is on out_data with out_valid=1 after edge N when the stage was EMPTY, or after the pop that frees main otherwise.
REQ-021 Entries SHALL leave in push order; no entry is dropped or duplicated while flush=0.
REQ-022 flush=1 SHALL force state to EMPTY on the next edge, overriding simultaneous push and pop; out_data SHALL then hold its prior value, and in_valid during that cycle is discarded.
REQ-023 When out_valid=0, out_data SHALL retain its last value; it SHALL change only on main register loads.
REQ-024 occupancy SHALL equal the entry count at every cycle: 0/1/2 for EMPTY/FULL/SKID.
REQ-025 Sustained in_valid=1 and out_ready=1 SHALL give one transfer per cycle with the stage staying in FULL.

Reset
REQ-026 While rst=1, regardless of clk: state = EMPTY, out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VALUE, skid register = RESET_VALUE.
REQ-027 Reset asserted mid-operation (FULL or SKID) SHALL discard all entries immediately; the first push after rst deasserts SHALL behave as from EMPTY.

Verification (WIDTH=8, RESET_VALUE=8'hA5)
REQ-028 Assert rst, then release -> out_data=8'hA5, out_valid=0, in_ready=1, occupancy=0.
REQ-029 Push 8'h11, 8'h22, 8'h33 with out_ready=1 -> out_data 8'h11, 8'h22, 8'h33 on consecutive cycles, occupancy stays 1.
REQ-030 out_ready=0; push 8'h44 then 8'h55 -> occupancy 2, in_ready=0, out_data=8'h44; a third in_valid (8'h66) is not accepted; raise out_ready -> 8'h44, 8'h55 in order, then occupancy 0.
REQ-031 State SKID holding 8'h77, 8'h88; flush=1 together with in_valid=1 and out_ready=1 -> next cycle occupancy 0, out_valid=0, in_ready=1, out_data=8'h77.
REQ-032 State FULL holding 8'h99; assert rst between clock edges -> outputs take reset values before the next edge, out_data=8'hA5.
REQ-033 Random in_valid/out_ready over 10000 cycles against a 2-deep FIFO model -> identical output order, no loss or duplication, occupancy always matches the model.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register. Handshake outputs are decoded
// from registered state only, so neither valid nor ready has a combinational path through the stage.
module pipe_stage_reg #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] main_reg;
  logic [WIDTH-1:0] skid_reg;
  logic             push;
  logic             pop;

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign out_data = main_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: if (push) state_next = FULL;
        FULL: begin
          if (push && !pop)      state_next = SKID;
          else if (!push && pop) state_next = EMPTY;
        end
        SKID:    if (pop) state_next = FULL;
        default: state_next = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    occupancy = 2'd0;
    case (state_reg)
      FULL: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      SKID: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
        occupancy = 2'd2;
      end
      default: ;
    endcase
  end

  // A flush leaves both data registers untouched so out_data keeps its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_reg <= RESET_VALUE;
      skid_reg <= RESET_VALUE;
    end else if (!flush) begin
      case (state_reg)
        EMPTY: if (push) main_reg <= in_data;
        FULL: begin
          if (push && pop) main_reg <= in_data;
          else if (push)   skid_reg <= in_data;
        end
        SKID:    if (pop) main_reg <= skid_reg;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized checks of pipe_stage_reg (WIDTH=8, RESET_VALUE=8'hA5)
// against hand-computed values and a 2-deep FIFO model.
module tb_pipe_stage_reg;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [1:0] occupancy;

  int n_cmp;
  int n_fail;

  pipe_stage_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL rst_hold_occ got=%0d exp=0", occupancy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_valid got=%b exp=0", out_valid); end
    rst = 1'b0;
    tick();
    n_cmp++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL reset_data got=%h exp=a5", out_data); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    $display("test_reset done: out_data=%h occ=%0d", out_data, occupancy);
  endtask

  task automatic test_pass_through();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      tick();
      n_cmp++; if (out_data !== vals[i] || out_valid !== 1'b1) begin n_fail++; $display("FAIL pass_data[%0d] got=%h/%b exp=%h/1", i, out_data, out_valid, vals[i]); end
      n_cmp++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL pass_occ[%0d] got=%0d exp=1", i, occupancy); end
      $display("pass_through push %h -> out_data=%h occ=%0d", vals[i], out_data, occupancy);
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL pass_drain got=%0d/%b exp=0/0", occupancy, out_valid); end
    n_cmp++; if (out_data !== 8'h33) begin n_fail++; $display("FAIL pass_retain got=%h exp=33", out_data); end
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h44; tick();
    in_data = 8'h55; tick();
    n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL skid_occ got=%0d exp=2", occupancy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_ready got=%b exp=0", in_ready); end
    n_cmp++; if (out_data !== 8'h44) begin n_fail++; $display("FAIL skid_data got=%h exp=44", out_data); end
    in_data = 8'h66; tick();
    n_cmp++; if (occupancy !== 2'd2 || out_data !== 8'h44) begin n_fail++; $display("FAIL skid_reject got=%0d/%h exp=2/44", occupancy, out_data); end
    in_valid = 1'b0; out_ready = 1'b1; tick();
    n_cmp++; if (out_data !== 8'h55 || occupancy !== 2'd1) begin n_fail++; $display("FAIL skid_pop1 got=%h/%0d exp=55/1", out_data, occupancy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_pop1_ready got=%b exp=1", in_ready); end
    tick();
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_pop2 got=%0d/%b exp=0/0", occupancy, out_valid); end
    n_cmp++; if (out_data !== 8'h55) begin n_fail++; $display("FAIL skid_retain got=%h exp=55", out_data); end
    $display("test_skid done: out_data=%h occ=%0d", out_data, occupancy);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h77; tick();
    in_data = 8'h88; tick();
    n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_setup got=%0d exp=2", occupancy); end
    flush = 1'b1; in_data = 8'h99; out_ready = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_hs got=%b/%b exp=0/1", out_valid, in_ready); end
    n_cmp++; if (out_data !== 8'h77) begin n_fail++; $display("FAIL flush_data got=%h exp=77", out_data); end
    tick();
    n_cmp++; if (occupancy !== 2'd0 || out_data !== 8'h77) begin n_fail++; $display("FAIL flush_idle got=%0d/%h exp=0/77", occupancy, out_data); end
    $display("test_flush done: out_data=%h occ=%0d", out_data, occupancy);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h99; tick();
    in_valid = 1'b0;
    n_cmp++; if (occupancy !== 2'd1 || out_data !== 8'h99) begin n_fail++; $display("FAIL areset_setup got=%0d/%h exp=1/99", occupancy, out_data); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL areset_data got=%h exp=a5", out_data); end
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin n_fail++; $display("FAIL areset_hs got=%b/%b/%0d exp=0/1/0", out_valid, in_ready, occupancy); end
    #1 rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h12; tick();
    in_valid = 1'b0;
    n_cmp++; if (out_data !== 8'h12 || occupancy !== 2'd1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_first got=%h/%0d/%b exp=12/1/1", out_data, occupancy, out_valid); end
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL areset_drain got=%0d exp=0", occupancy); end
    $display("test_async_reset done: out_data=%h occ=%0d", out_data, occupancy);
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    logic       push;
    logic       pop;
    logic       fl;
    int         start_fail;
    start_fail = n_fail;
    for (int c = 0; c < 10000; c++) begin
      n_cmp++; if (occupancy !== 2'(q.size())) begin n_fail++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", c, occupancy, q.size()); end
      n_cmp++; if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_hs cyc=%0d got=%b/%b exp=%b/%b", c, out_valid, in_ready, q.size() > 0, q.size() < 2); end
      if (q.size() > 0) begin
        n_cmp++; if (out_data !== q[0]) begin n_fail++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, out_data, q[0]); end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom_range(0, 255));
      fl        = ($urandom_range(0, 99) == 0);
      flush     = fl;
      push = in_valid && (q.size() < 2);
      pop  = out_ready && (q.size() > 0);
      tick();
      if (fl) begin
        q.delete();
      end else begin
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(in_data);
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    $display("test_random done: 10000 cycles, %0d new mismatches", n_fail - start_fail);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_pass_through();
    test_skid();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
